// File: rtl/glb_bus_arb.sv
// glb_bus_arb: round-robin sequencer for the shared global array bus.
// Registered grant and bus strobes; read tags ride a pipe matched to the array read latency.
module glb_bus_arb #(
    parameter int NREQ      = 3,
    parameter int ADR_W     = 12,
    parameter int DATA_W    = 25,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ-1:0]          OP_WE,
    input  logic [NREQ-1:0]          OP_RE,
    input  logic [NREQ*ADR_W-1:0]    OP_ADR,
    input  logic [NREQ*DATA_W-1:0]   OP_WDATA,
    input  logic                     HOLD,
    input  logic [DATA_W-1:0]        GLB_RDATA,
    output logic [NREQ-1:0]          GNT,
    output logic [DATA_W-1:0]        RDATA,
    output logic [NREQ-1:0]          RVALID,
    output logic [ADR_W-1:0]         GLB_ADR,
    output logic [DATA_W-1:0]        GLB_WDATA,
    output logic                     GLB_WE,
    output logic                     GLB_RE,
    output logic                     ERR
);
    localparam int          OW = (NREQ > 2) ? 2 : 1;
    localparam int          CW = $clog2(MAX_BURST + 1);
    localparam int unsigned NR = NREQ;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]      state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] tag_q [RD_LAT+1];

    logic              op_we, op_re, accept, burst_hit;
    logic [ADR_W-1:0]  op_adr;
    logic [DATA_W-1:0] op_wdata;
    logic              at_found, nx_found;
    logic [OW-1:0]     at_sel, nx_sel, nx_ptr;
    logic [NREQ-1:0]   at_oh, nx_oh;

    always_comb begin
        int unsigned ia;
        int unsigned in;
        ia       = 0;
        in       = 0;
        op_we    = OP_WE[owner_q];
        op_re    = OP_RE[owner_q];
        op_adr   = OP_ADR[owner_q*ADR_W +: ADR_W];
        op_wdata = OP_WDATA[owner_q*DATA_W +: DATA_W];
        accept   = (state_q == ST_OWN) && REQ[owner_q] && (op_we || op_re);
        burst_hit = accept && (cnt_q == CW'(MAX_BURST - 1));

        // at_sel: first requester at or after the pointer; nx_sel: first one strictly after the owner
        at_found = 1'b0;
        at_sel   = '0;
        nx_found = 1'b0;
        nx_sel   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            ia = 32'(ptr_q) + k;
            if (ia >= NR) ia = ia - NR;
            if (!at_found && REQ[ia]) begin
                at_found = 1'b1;
                at_sel   = OW'(ia);
            end
        end
        for (int unsigned k = 1; k < NR; k++) begin
            in = 32'(owner_q) + k;
            if (in >= NR) in = in - NR;
            if (!nx_found && REQ[in]) begin
                nx_found = 1'b1;
                nx_sel   = OW'(in);
            end
        end
        nx_ptr = (32'(nx_sel) == NR - 1) ? '0 : nx_sel + 1'b1;
        at_oh  = '0;
        at_oh[at_sel] = 1'b1;
        nx_oh  = '0;
        nx_oh[nx_sel] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            GNT       <= '0;
            RDATA     <= '0;
            RVALID    <= '0;
            GLB_ADR   <= '0;
            GLB_WDATA <= '0;
            GLB_WE    <= 1'b0;
            GLB_RE    <= 1'b0;
            ERR       <= 1'b0;
            for (int unsigned i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            GLB_WE <= 1'b0;
            GLB_RE <= 1'b0;
            if (accept) begin
                GLB_ADR   <= op_adr;
                GLB_WDATA <= op_wdata;
                GLB_WE    <= op_we;
                GLB_RE    <= op_re && !op_we;
                if (op_we && op_re) ERR <= 1'b1;
            end

            tag_q[0] <= (accept && op_re && !op_we) ? GNT : '0;
            for (int unsigned i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            RVALID <= tag_q[RD_LAT];
            if (|tag_q[RD_LAT]) RDATA <= GLB_RDATA;

            case (state_q)
                ST_IDLE: begin
                    if (!HOLD && at_found) begin
                        state_q <= ST_OWN;
                        owner_q <= at_sel;
                        GNT     <= at_oh;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (HOLD) begin
                        state_q <= ST_IDLE;
                        GNT     <= '0;
                        cnt_q   <= '0;
                    end else if (!REQ[owner_q] || (burst_hit && nx_found)) begin
                        cnt_q <= '0;
                        if (nx_found) begin
                            owner_q <= nx_sel;
                            GNT     <= nx_oh;
                            ptr_q   <= nx_ptr;
                        end else begin
                            state_q <= ST_IDLE;
                            GNT     <= '0;
                        end
                    end else if (accept) begin
                        // lone requester at the limit keeps the bus; count simply wraps
                        cnt_q <= burst_hit ? '0 : cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_glb_bus_arb.sv
// tb_glb_bus_arb: directed vector table plus hand sequences for burst limit, read return and reset.
module tb_glb_bus_arb;
    localparam int RD_LAT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  REQ, OP_WE, OP_RE;
    logic [35:0] OP_ADR;
    logic [74:0] OP_WDATA;
    logic        HOLD;
    logic [24:0] GLB_RDATA;
    logic [2:0]  GNT, RVALID;
    logic [24:0] RDATA, GLB_WDATA;
    logic [11:0] GLB_ADR;
    logic        GLB_WE, GLB_RE, ERR;

    int checks = 0;
    int failures = 0;

    glb_bus_arb #(.NREQ(3), .ADR_W(12), .DATA_W(25), .RD_LAT(RD_LAT), .MAX_BURST(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP_WE(OP_WE), .OP_RE(OP_RE),
        .OP_ADR(OP_ADR), .OP_WDATA(OP_WDATA), .HOLD(HOLD), .GLB_RDATA(GLB_RDATA),
        .GNT(GNT), .RDATA(RDATA), .RVALID(RVALID), .GLB_ADR(GLB_ADR),
        .GLB_WDATA(GLB_WDATA), .GLB_WE(GLB_WE), .GLB_RE(GLB_RE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [24:0] wd(input logic [11:0] a);
        return 25'h100000 | {13'd0, a};
    endfunction

    function automatic logic [24:0] arr_f(input logic [11:0] a);
        if (a == 12'h880) return 25'h1ABCDE;
        return {1'b0, a, a};
    endfunction

    // array model: samples the bus strobe, returns data RD_LAT cycles later
    logic [RD_LAT-1:0] m_v = '0;
    logic [11:0]       m_a [RD_LAT];
    always @(posedge CLK) begin
        m_v[0] <= GLB_RE;
        m_a[0] <= GLB_ADR;
        for (int i = 1; i < RD_LAT; i++) begin
            m_v[i] <= m_v[i-1];
            m_a[i] <= m_a[i-1];
        end
    end
    assign GLB_RDATA = m_v[RD_LAT-1] ? arr_f(m_a[RD_LAT-1]) : 25'h0BAD00;

    typedef struct {
        logic [2:0]  req, we, re;
        logic        hold;
        logic [11:0] base;
        logic [2:0]  gnt;
        logic        swe, sre;
        logic [11:0] adr;
        logic        err;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [2:0] req, we, re, input logic hold,
                                input logic [11:0] base, input logic [2:0] gnt,
                                input logic swe, sre, input logic [11:0] adr, input logic err);
        vec_t v;
        v.req = req; v.we = we; v.re = re; v.hold = hold; v.base = base;
        v.gnt = gnt; v.swe = swe; v.sre = sre; v.adr = adr; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input logic [2:0] req, we, re, input logic [11:0] base);
        REQ = req;
        OP_WE = we;
        OP_RE = re;
        for (int i = 0; i < 3; i++) begin
            OP_ADR[i*12 +: 12]   = base + 12'(i * 256);
            OP_WDATA[i*25 +: 25] = wd(base + 12'(i * 256));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(GNT), 0);
        chk({tag, "_rvalid"}, 32'(RVALID), 0);
        chk({tag, "_rdata"}, 32'(RDATA), 0);
        chk({tag, "_adr"}, 32'(GLB_ADR), 0);
        chk({tag, "_wdata"}, 32'(GLB_WDATA), 0);
        chk({tag, "_we"}, 32'(GLB_WE), 0);
        chk({tag, "_re"}, 32'(GLB_RE), 0);
        chk({tag, "_err"}, 32'(ERR), 0);
    endtask

    initial begin
        // single-owner write burst
        tv.push_back(mk(3'b001, 3'b001, 3'b000, 0, 12'h010, 3'b001, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b001, 3'b001, 3'b000, 0, 12'h010, 3'b001, 1, 0, 12'h010, 0));
        tv.push_back(mk(3'b001, 3'b001, 3'b000, 0, 12'h011, 3'b001, 1, 0, 12'h011, 0));
        tv.push_back(mk(3'b001, 3'b001, 3'b000, 0, 12'h012, 3'b001, 1, 0, 12'h012, 0));
        tv.push_back(mk(3'b000, 3'b000, 3'b000, 0, 12'h000, 3'b000, 0, 0, 12'h000, 0));
        // round robin 0,1,2
        tv.push_back(mk(3'b111, 3'b000, 3'b000, 0, 12'h020, 3'b001, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b111, 3'b001, 3'b000, 0, 12'h020, 3'b001, 1, 0, 12'h020, 0));
        tv.push_back(mk(3'b111, 3'b001, 3'b000, 0, 12'h021, 3'b001, 1, 0, 12'h021, 0));
        tv.push_back(mk(3'b110, 3'b000, 3'b000, 0, 12'h030, 3'b010, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b110, 3'b010, 3'b000, 0, 12'h030, 3'b010, 1, 0, 12'h130, 0));
        tv.push_back(mk(3'b110, 3'b010, 3'b000, 0, 12'h031, 3'b010, 1, 0, 12'h131, 0));
        tv.push_back(mk(3'b100, 3'b000, 3'b000, 0, 12'h040, 3'b100, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 0, 12'h040, 3'b100, 1, 0, 12'h240, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 0, 12'h041, 3'b100, 1, 0, 12'h241, 0));
        tv.push_back(mk(3'b000, 3'b000, 3'b000, 0, 12'h000, 3'b000, 0, 0, 12'h000, 0));
        // HOLD mid-burst
        tv.push_back(mk(3'b100, 3'b000, 3'b000, 0, 12'h050, 3'b100, 0, 0, 12'h000, 0));
        for (int b = 0; b < 5; b++)
            tv.push_back(mk(3'b100, 3'b100, 3'b000, 0, 12'h050 + 12'(b), 3'b100, 1, 0, 12'h250 + 12'(b), 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 1, 12'h055, 3'b000, 1, 0, 12'h255, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 1, 12'h056, 3'b000, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 1, 12'h056, 3'b000, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 0, 12'h056, 3'b100, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 0, 12'h056, 3'b100, 1, 0, 12'h256, 0));
        tv.push_back(mk(3'b100, 3'b100, 3'b000, 0, 12'h057, 3'b100, 1, 0, 12'h257, 0));
        tv.push_back(mk(3'b000, 3'b000, 3'b000, 0, 12'h000, 3'b000, 0, 0, 12'h000, 0));
        // write+read together
        tv.push_back(mk(3'b010, 3'b000, 3'b000, 0, 12'h060, 3'b010, 0, 0, 12'h000, 0));
        tv.push_back(mk(3'b010, 3'b010, 3'b010, 0, 12'h060, 3'b010, 1, 0, 12'h160, 1));
        tv.push_back(mk(3'b010, 3'b000, 3'b000, 0, 12'h060, 3'b010, 0, 0, 12'h000, 1));
        tv.push_back(mk(3'b000, 3'b000, 3'b000, 0, 12'h000, 3'b000, 0, 0, 12'h000, 1));

        RST = 1'b1;
        HOLD = 1'b0;
        set_ops(3'b000, 3'b000, 3'b000, 12'h000);
        step();
        step();
        chk_all_zero("reset");
        RST = 1'b0;

        foreach (tv[i]) begin
            set_ops(tv[i].req, tv[i].we, tv[i].re, tv[i].base);
            HOLD = tv[i].hold;
            step();
            chk($sformatf("vec%0d_gnt", i), 32'(GNT), 32'(tv[i].gnt));
            chk($sformatf("vec%0d_we", i), 32'(GLB_WE), 32'(tv[i].swe));
            chk($sformatf("vec%0d_re", i), 32'(GLB_RE), 32'(tv[i].sre));
            chk($sformatf("vec%0d_err", i), 32'(ERR), 32'(tv[i].err));
            chk($sformatf("vec%0d_rvalid", i), 32'(RVALID), 0);
            if (tv[i].swe || tv[i].sre)
                chk($sformatf("vec%0d_adr", i), 32'(GLB_ADR), 32'(tv[i].adr));
            if (tv[i].swe)
                chk($sformatf("vec%0d_wdata", i), 32'(GLB_WDATA), 32'(wd(tv[i].adr)));
        end
        HOLD = 1'b0;

        // burst limit: requester 0 streams while requester 1 waits
        set_ops(3'b011, 3'b000, 3'b000, 12'h300);
        step();
        chk("bl_grant0", 32'(GNT), 32'(3'b001));
        for (int b = 0; b < 16; b++) begin
            set_ops(3'b011, 3'b001, 3'b000, 12'h300 + 12'(b));
            step();
            chk($sformatf("bl_we%0d", b), 32'(GLB_WE), 1);
            chk($sformatf("bl_adr%0d", b), 32'(GLB_ADR), 32'(12'h300 + 12'(b)));
            chk($sformatf("bl_gnt%0d", b), 32'(GNT), (b == 15) ? 32'(3'b010) : 32'(3'b001));
        end
        set_ops(3'b011, 3'b010, 3'b000, 12'h3A0);
        step();
        chk("bl_r1_gnt", 32'(GNT), 32'(3'b010));
        chk("bl_r1_adr", 32'(GLB_ADR), 32'h4A0);
        set_ops(3'b001, 3'b000, 3'b000, 12'h300);
        step();
        chk("bl_back_gnt", 32'(GNT), 32'(3'b001));
        for (int b = 16; b < 20; b++) begin
            set_ops(3'b001, 3'b001, 3'b000, 12'h300 + 12'(b));
            step();
            chk($sformatf("bl_we%0d", b), 32'(GLB_WE), 1);
            chk($sformatf("bl_adr%0d", b), 32'(GLB_ADR), 32'(12'h300 + 12'(b)));
        end
        set_ops(3'b000, 3'b000, 3'b000, 12'h000);
        step();
        chk("bl_idle", 32'(GNT), 0);

        // read return with grant moving to requester 2 while the read is in flight
        set_ops(3'b010, 3'b000, 3'b000, 12'h780);
        step();
        chk("rd_gnt1", 32'(GNT), 32'(3'b010));
        set_ops(3'b110, 3'b000, 3'b010, 12'h780);
        step();
        chk("rd_re", 32'(GLB_RE), 1);
        chk("rd_we", 32'(GLB_WE), 0);
        chk("rd_adr", 32'(GLB_ADR), 32'h880);
        set_ops(3'b100, 3'b000, 3'b000, 12'h780);
        step();
        chk("rd_gnt2", 32'(GNT), 32'(3'b100));
        chk("rd_rv1", 32'(RVALID), 0);
        step();
        chk("rd_rv2", 32'(RVALID), 0);
        step();
        chk("rd_rv3", 32'(RVALID), 32'(3'b010));
        chk("rd_data", 32'(RDATA), 32'h1ABCDE);
        step();
        chk("rd_rv4", 32'(RVALID), 0);
        chk("err_sticky", 32'(ERR), 1);

        // back-to-back reads return in order
        set_ops(3'b100, 3'b000, 3'b100, 12'h780);
        step();
        chk("bb_adr0", 32'(GLB_ADR), 32'h980);
        set_ops(3'b100, 3'b000, 3'b100, 12'h781);
        step();
        chk("bb_adr1", 32'(GLB_ADR), 32'h981);
        set_ops(3'b100, 3'b000, 3'b000, 12'h781);
        step();
        chk("bb_rv_early", 32'(RVALID), 0);
        step();
        chk("bb_rv0", 32'(RVALID), 32'(3'b100));
        chk("bb_data0", 32'(RDATA), 32'(arr_f(12'h980)));
        step();
        chk("bb_rv1", 32'(RVALID), 32'(3'b100));
        chk("bb_data1", 32'(RDATA), 32'(arr_f(12'h981)));
        step();
        chk("bb_rv_end", 32'(RVALID), 0);

        // reset with two reads in flight
        set_ops(3'b100, 3'b000, 3'b100, 12'h790);
        step();
        set_ops(3'b100, 3'b000, 3'b100, 12'h791);
        step();
        set_ops(3'b000, 3'b000, 3'b000, 12'h000);
        RST = 1'b1;
        step();
        chk_all_zero("mid_rst");
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("post_rst_rv%0d", c), 32'(RVALID), 0);
            chk($sformatf("post_rst_rd%0d", c), 32'(RDATA), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
